// File: rtl/grid_ram_arbiter_pkg.sv
// ============================================================================
// Module : grid_ram_arbiter_pkg
// Brief  : Playfield dimensions, cell encodings and shared types.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package grid_ram_arbiter_pkg;

    localparam int GRID_WIDTH     = 16;
    localparam int GRID_HEIGHT    = 12;
    localparam int BITS_PER_BLOCK = 2;

    localparam logic [BITS_PER_BLOCK-1:0] BLOCK_EMPTY = 2'd0;
    localparam logic [BITS_PER_BLOCK-1:0] BLOCK_WALL  = 2'd1;
    localparam logic [BITS_PER_BLOCK-1:0] BLOCK_SNAKE = 2'd2;
    localparam logic [BITS_PER_BLOCK-1:0] BLOCK_FOOD  = 2'd3;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CLR  = 2'd2,
        OWN_GAME = 2'd3
    } owner_t;

    function automatic logic is_border(input int x, input int y, input int gw, input int gh);
        return (x == 0) || (x == gw - 1) || (y == 0) || (y == gh - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/grid_ram_arbiter_ram.sv
// ============================================================================
// Module : grid_ram
// Brief  : Single-port synchronous RAM, registered read, write-first.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module grid_ram #(
    parameter int DEPTH = 192,
    parameter int AW    = 8,
    parameter int DW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_q;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
            r_q         <= wdata;
        end else begin
            r_q         <= r_mem[addr];
        end
    end

    assign rdata = r_q;

endmodule

`default_nettype wire

// File: rtl/grid_ram_arbiter.sv
// ============================================================================
// Module : grid_ram_arbiter
// Brief  : Playfield cell store shared by VGA scanner, game engine and clear engine.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module grid_ram_arbiter
    import grid_ram_arbiter_pkg::*;
#(
    parameter int GW  = GRID_WIDTH,
    parameter int GH  = GRID_HEIGHT,
    parameter int BPB = BITS_PER_BLOCK,
    parameter int XW  = 4,
    parameter int YW  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           vid_req,
    input  logic [XW-1:0]  vid_x,
    input  logic [YW-1:0]  vid_y,
    output logic           vid_rvalid,
    output logic [BPB-1:0] vid_rdata,
    input  logic           game_req,
    input  logic           game_we,
    input  logic [XW-1:0]  game_x,
    input  logic [YW-1:0]  game_y,
    input  logic [BPB-1:0] game_wdata,
    output logic           game_gnt,
    output logic           game_rvalid,
    output logic [BPB-1:0] game_rdata,
    input  logic           clear_start,
    output logic           clear_busy,
    output logic           clear_done
);

    localparam int CELLS = GW * GH;
    localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;

    logic [0:0]     r_state;
    logic [XW-1:0]  r_clr_x;
    logic [YW-1:0]  r_clr_y;
    logic           r_vid_valid;
    logic           r_game_valid;
    logic           r_rd_oor;

    owner_t         w_owner;
    logic [XW-1:0]  w_x;
    logic [YW-1:0]  w_y;
    logic           w_we;
    logic [BPB-1:0] w_wdata;
    logic           w_oor;
    logic [AW-1:0]  w_addr;
    logic           w_ram_we;
    logic [BPB-1:0] w_ram_q;
    logic           w_clr_last;

    // Fixed priority: video never stalls, clear beats game, game only when idle.
    always_comb begin
        w_owner = OWN_NONE;
        if (vid_req) begin
            w_owner = OWN_VID;
        end else if (r_state == ST_CLEAR) begin
            w_owner = OWN_CLR;
        end else if (game_req) begin
            w_owner = OWN_GAME;
        end
    end

    always_comb begin
        w_x     = vid_x;
        w_y     = vid_y;
        w_we    = 1'b0;
        w_wdata = '0;
        case (w_owner)
            OWN_CLR: begin
                w_x     = r_clr_x;
                w_y     = r_clr_y;
                w_we    = 1'b1;
                w_wdata = is_border(int'(r_clr_x), int'(r_clr_y), GW, GH) ?
                          BPB'(BLOCK_WALL) : BPB'(BLOCK_EMPTY);
            end
            OWN_GAME: begin
                w_x     = game_x;
                w_y     = game_y;
                w_we    = game_we;
                w_wdata = game_wdata;
            end
            default: ;
        endcase
    end

    assign w_oor      = (int'(w_x) >= GW) || (int'(w_y) >= GH);
    assign w_addr     = w_oor ? '0 : AW'(int'(w_y) * GW + int'(w_x));
    // Reset holds the clear engine as owner; keep it from writing until released.
    assign w_ram_we   = w_we && !w_oor && !rst;
    assign w_clr_last = (r_clr_x == XW'(GW - 1)) && (r_clr_y == YW'(GH - 1));

    grid_ram #(
        .DEPTH (CELLS),
        .AW    (AW),
        .DW    (BPB)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_addr),
        .wdata (w_wdata),
        .rdata (w_ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_CLEAR;
            r_clr_x      <= '0;
            r_clr_y      <= '0;
            r_vid_valid  <= 1'b0;
            r_game_valid <= 1'b0;
            r_rd_oor     <= 1'b0;
        end else begin
            r_vid_valid  <= vid_req;
            r_game_valid <= (w_owner == OWN_GAME) && !game_we;
            r_rd_oor     <= w_oor;
            if (clear_start) begin
                r_state <= ST_CLEAR;
                r_clr_x <= '0;
                r_clr_y <= '0;
            end else if (w_owner == OWN_CLR) begin
                if (w_clr_last) begin
                    r_state <= ST_IDLE;
                    r_clr_x <= '0;
                    r_clr_y <= '0;
                end else if (r_clr_x == XW'(GW - 1)) begin
                    r_clr_x <= '0;
                    r_clr_y <= r_clr_y + 1'b1;
                end else begin
                    r_clr_x <= r_clr_x + 1'b1;
                end
            end
        end
    end

    assign vid_rvalid  = r_vid_valid;
    assign vid_rdata   = r_vid_valid ? (r_rd_oor ? BPB'(BLOCK_WALL) : w_ram_q) : '0;
    assign game_rvalid = r_game_valid;
    assign game_rdata  = r_game_valid ? (r_rd_oor ? BPB'(BLOCK_WALL) : w_ram_q) : '0;
    assign game_gnt    = (w_owner == OWN_GAME);
    assign clear_busy  = (r_state == ST_CLEAR);
    assign clear_done  = (w_owner == OWN_CLR) && w_clr_last && !clear_start;

endmodule

`default_nettype wire

// File: tb/tb_grid_ram_arbiter.sv
// ============================================================================
// Module : tb_grid_ram_arbiter
// Brief  : Self-checking bench for grid_ram_arbiter with a cell-array reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_grid_ram_arbiter;
    import grid_ram_arbiter_pkg::*;

    localparam int GW    = 16;
    localparam int GH    = 12;
    localparam int BPB   = 2;
    localparam int XW    = 5;
    localparam int YW    = 4;
    localparam int CELLS = GW * GH;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           vid_req = 1'b0;
    logic [XW-1:0]  vid_x = '0;
    logic [YW-1:0]  vid_y = '0;
    logic           vid_rvalid;
    logic [BPB-1:0] vid_rdata;
    logic           game_req = 1'b0;
    logic           game_we = 1'b0;
    logic [XW-1:0]  game_x = '0;
    logic [YW-1:0]  game_y = '0;
    logic [BPB-1:0] game_wdata = '0;
    logic           game_gnt;
    logic           game_rvalid;
    logic [BPB-1:0] game_rdata;
    logic           clear_start = 1'b0;
    logic           clear_busy;
    logic           clear_done;

    int checks = 0;
    int errors = 0;

    grid_ram_arbiter #(.GW(GW), .GH(GH), .BPB(BPB), .XW(XW), .YW(YW)) dut (
        .clk(clk), .rst(rst),
        .vid_req(vid_req), .vid_x(vid_x), .vid_y(vid_y),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .game_req(game_req), .game_we(game_we), .game_x(game_x), .game_y(game_y),
        .game_wdata(game_wdata), .game_gnt(game_gnt),
        .game_rvalid(game_rvalid), .game_rdata(game_rdata),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: flat cell array, clear pass as a running cell index.
    logic [1:0] m_mem   [CELLS];
    bit         m_known [CELLS];
    bit         m_clearing = 1'b1;
    int         m_idx = 0;
    bit         m_pv = 1'b0, m_pg = 1'b0, m_pvk = 1'b0, m_pgk = 1'b0;
    logic [1:0] m_pvd = '0, m_pgd = '0;

    function automatic void mread(input int x, input int y, output logic [1:0] d, output bit k);
        if (x >= GW || y >= GH) begin
            d = BLOCK_WALL;
            k = 1'b1;
        end else begin
            d = m_mem[y * GW + x];
            k = m_known[y * GW + x];
        end
    endfunction

    initial begin
        forever begin
            bit own_vid, own_clr, own_game;
            int cx, cy;
            @(negedge clk);
            if (rst) begin
                chk("rst_busy", clear_busy, 1);
                chk("rst_gnt", game_gnt, 0);
                chk("rst_done", clear_done, 0);
                chk("rst_vid_rvalid", vid_rvalid, 0);
                chk("rst_vid_rdata", vid_rdata, 0);
                chk("rst_game_rvalid", game_rvalid, 0);
                chk("rst_game_rdata", game_rdata, 0);
                m_clearing = 1'b1;
                m_idx      = 0;
                m_pv       = 1'b0;
                m_pg       = 1'b0;
            end else begin
                own_vid  = vid_req;
                own_clr  = !vid_req && m_clearing;
                own_game = !vid_req && !m_clearing && game_req;
                chk("busy", clear_busy, m_clearing);
                chk("gnt", game_gnt, own_game);
                chk("done", clear_done, own_clr && (m_idx == CELLS - 1) && !clear_start);
                chk("vid_rvalid", vid_rvalid, m_pv);
                if (m_pv && m_pvk) chk("vid_rdata", vid_rdata, m_pvd);
                chk("game_rvalid", game_rvalid, m_pg);
                if (m_pg && m_pgk) chk("game_rdata", game_rdata, m_pgd);

                m_pv = own_vid;
                if (own_vid) mread(int'(vid_x), int'(vid_y), m_pvd, m_pvk);
                m_pg = own_game && !game_we;
                if (m_pg) mread(int'(game_x), int'(game_y), m_pgd, m_pgk);
                if (own_game && game_we && int'(game_x) < GW && int'(game_y) < GH) begin
                    m_mem[int'(game_y) * GW + int'(game_x)]   = game_wdata;
                    m_known[int'(game_y) * GW + int'(game_x)] = 1'b1;
                end
                if (own_clr) begin
                    cx = m_idx % GW;
                    cy = m_idx / GW;
                    m_mem[m_idx]   = (cx == 0 || cx == GW - 1 || cy == 0 || cy == GH - 1) ?
                                     BLOCK_WALL : BLOCK_EMPTY;
                    m_known[m_idx] = 1'b1;
                end
                if (clear_start) begin
                    m_clearing = 1'b1;
                    m_idx      = 0;
                end else if (own_clr) begin
                    if (m_idx == CELLS - 1) begin
                        m_clearing = 1'b0;
                        m_idx      = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles (1 = first cycle) until clear_done; returns 0 on timeout.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 1000; i++) begin
            #3;
            if (clear_done) begin
                n = i;
                break;
            end
            @(posedge clk);
            #1;
        end
        tick();
    endtask

    task automatic game_op(input bit we, input int x, input int y, input logic [1:0] d,
                           output int wait_cycles, output logic [1:0] rd, output bit rv);
        game_req   = 1'b1;
        game_we    = we;
        game_x     = XW'(x);
        game_y     = YW'(y);
        game_wdata = d;
        wait_cycles = -1;
        for (int i = 0; i < 300; i++) begin
            #3;
            if (game_gnt) begin
                wait_cycles = i;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (wait_cycles >= 0) tick();
        game_req = 1'b0;
        rv = game_rvalid;
        rd = game_rdata;
    endtask

    initial begin
        int n, w, vcnt, done_at, ng, ndone;
        logic [1:0] rd;
        bit rv, lastg;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Automatic clear after reset release
        wait_done(n);
        chk("t1_done_cycle", n, 192);
        chk("t1_busy_fell", clear_busy, 0);
        game_op(1'b0, 0, 5, 2'd0, w, rd, rv);
        chk("t1_read_0_5_valid", rv, 1);
        chk("t1_read_0_5", rd, 1);
        game_op(1'b0, 5, 5, 2'd0, w, rd, rv);
        chk("t1_read_5_5", rd, 0);

        // Clear delayed by exactly 100 video cycles
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        vcnt = 0;
        done_at = 0;
        for (int i = 1; i <= 500 && done_at == 0; i++) begin
            if (i <= 150 && vcnt < 100 && (($urandom % 3) != 0 || (151 - i) <= (100 - vcnt))) begin
                vid_req = 1'b1;
                vcnt++;
                vid_x = XW'($urandom_range(0, 17));
                vid_y = YW'($urandom_range(0, 13));
            end else begin
                vid_req = 1'b0;
            end
            #3;
            if (clear_done) done_at = i;
            tick();
        end
        vid_req = 1'b0;
        chk("t2_vid_cycles", vcnt, 100);
        chk("t2_done_cycle", done_at, 292);

        // Game write then read back
        game_op(1'b1, 3, 4, BLOCK_SNAKE, w, rd, rv);
        chk("t3_write_wait", w, 0);
        chk("t3_write_no_rvalid", rv, 0);
        game_op(1'b0, 3, 4, 2'd0, w, rd, rv);
        chk("t3_read_wait", w, 0);
        chk("t3_read_rvalid", rv, 1);
        chk("t3_read_data", rd, 2);

        // Starvation under video, grant the cycle video drops
        game_req = 1'b1;
        game_we  = 1'b0;
        game_x   = XW'(3);
        game_y   = YW'(4);
        ng = 0;
        for (int i = 0; i < 20; i++) begin
            vid_req = 1'b1;
            vid_x = XW'($urandom_range(0, 15));
            vid_y = YW'($urandom_range(0, 11));
            #3;
            if (game_gnt) ng++;
            tick();
        end
        vid_req = 1'b0;
        #3;
        chk("t4_starved_gnts", ng, 0);
        chk("t4_gnt_on_drop", game_gnt, 1);
        tick();
        game_req = 1'b0;
        chk("t4_rvalid", game_rvalid, 1);
        chk("t4_rdata", game_rdata, 2);

        // Out-of-range write dropped, read gives wall
        game_op(1'b1, 16, 2, BLOCK_SNAKE, w, rd, rv);
        chk("t5_oor_write_wait", w, 0);
        game_op(1'b0, 16, 2, 2'd0, w, rd, rv);
        chk("t5_oor_read_valid", rv, 1);
        chk("t5_oor_read", rd, 1);
        game_op(1'b0, 0, 2, 2'd0, w, rd, rv);
        chk("t5_cell_0_2", rd, 1);

        // Restart at cell 50
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 50; i++) begin
            #3;
            if (clear_done) ndone++;
            tick();
        end
        clear_start = 1'b1;
        #3;
        if (clear_done) ndone++;
        tick();
        clear_start = 1'b0;
        wait_done(n);
        chk("t6_aborted_done", ndone, 0);
        chk("t6_restart_done_cycle", n, 192);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            #3;
            if (clear_done) ndone++;
            tick();
        end
        chk("t6_extra_done", ndone, 0);

        // Reset in the middle of a clear with a pending game request
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (30) tick();
        vid_req  = 1'b1;
        game_req = 1'b1;
        tick();
        chk("t6_pre_rst_vid_rvalid", vid_rvalid, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_vid_rvalid", vid_rvalid, 0);
        chk("t6_rst_busy", clear_busy, 1);
        chk("t6_rst_gnt", game_gnt, 0);
        vid_req  = 1'b0;
        game_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        wait_done(n);
        chk("t6_post_rst_done_cycle", n, 192);

        // Randomized traffic against the model
        lastg = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            vid_req     = ($urandom_range(0, 2) == 0);
            vid_x       = XW'($urandom_range(0, 17));
            vid_y       = YW'($urandom_range(0, 13));
            clear_start = ($urandom_range(0, 499) == 0);
            if (!game_req || lastg) begin
                game_req   = $urandom_range(0, 1) == 1;
                game_we    = $urandom_range(0, 1) == 1;
                game_x     = XW'($urandom_range(0, 17));
                game_y     = YW'($urandom_range(0, 13));
                game_wdata = 2'($urandom_range(0, 3));
            end
            #3;
            lastg = game_gnt;
            tick();
        end
        vid_req     = 1'b0;
        game_req    = 1'b0;
        clear_start = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
